// File: rtl/ram_arb.sv
// ram_arb: three-way arbiter (video, CPU, DMA) in front of a single-port
// 16-bit RAM. The masters' requests are handled one access at a time. Each
// access runs IDLE -> ISSUE -> WAIT -> DONE. A watchdog force-completes any
// access that the RAM never acknowledges, and flags it with err.
//
// Optional feature: define RAM_ARB_FAIR_EN to make CPU and DMA share the RAM
// round-robin. In the default build CPU always beats DMA.
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its access into ram_* regs
// ISSUE | ram_req high for one cycle
// WAIT  | wait for ram_ack, count cycles toward the timeout
// DONE  | winner's ack (and err on timeout) high for one cycle

module ram_arb #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        vid_req_i,
    input  logic [17:0] vid_addr_i,
    output logic        vid_ack_o,
    output logic [15:0] vid_rdata_o,
    output logic        vid_err_o,

    input  logic        cpu_req_i,
    input  logic [17:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic [1:0]  cpu_wstrb_i,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_rdata_o,
    output logic        cpu_err_o,

    input  logic        dma_req_i,
    input  logic [17:0] dma_addr_i,
    input  logic        dma_we_i,
    input  logic [15:0] dma_wdata_i,
    input  logic [1:0]  dma_wstrb_i,
    output logic        dma_ack_o,
    output logic [15:0] dma_rdata_o,
    output logic        dma_err_o,

    output logic        ram_req_o,
    output logic [17:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    output logic [1:0]  ram_wstrb_o,
    output logic        ram_we_o,
    input  logic        ram_ack_i,
    input  logic [15:0] ram_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_VID = 2'd0,
        M_CPU = 2'd1,
        M_DMA = 2'd2
    } master_t;

    localparam logic [3:0] TO_VAL = TIMEOUT[3:0];

    state_t      state_q;
    master_t     win_q;
    master_t     win_d;
    logic        any_req_d;
    logic [3:0]  cnt_q;

    logic        vid_ack_q, cpu_ack_q, dma_ack_q;
    logic        vid_err_q, cpu_err_q, dma_err_q;
    logic [15:0] vid_rdata_q, cpu_rdata_q, dma_rdata_q;

    logic        ram_req_q;
    logic [17:0] ram_addr_q;
    logic [15:0] ram_wdata_q;
    logic [1:0]  ram_wstrb_q;
    logic        ram_we_q;

`ifdef RAM_ARB_FAIR_EN
    // 0 = CPU favoured on a CPU/DMA tie, 1 = DMA favoured
    logic        ptr_q;
`endif

    // Pick the winner among the pending requests; video always goes first
    always_comb begin
        any_req_d = vid_req_i | cpu_req_i | dma_req_i;
        win_d     = M_VID;
        if (vid_req_i) begin
            win_d = M_VID;
        end else if (cpu_req_i && dma_req_i) begin
`ifdef RAM_ARB_FAIR_EN
            win_d = ptr_q ? M_DMA : M_CPU;
`else
            win_d = M_CPU;
`endif
        end else if (cpu_req_i) begin
            win_d = M_CPU;
        end else if (dma_req_i) begin
            win_d = M_DMA;
        end
    end

    // Access sequencer with registered acks, errs, rdata and RAM side
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            win_q       <= M_VID;
            cnt_q       <= 4'd0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            vid_err_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            vid_rdata_q <= 16'h0000;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= 18'h00000;
            ram_wdata_q <= 16'h0000;
            ram_wstrb_q <= 2'b00;
            ram_we_q    <= 1'b0;
`ifdef RAM_ARB_FAIR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            // acks, errs and ram_req are single-cycle pulses
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            vid_err_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
            ram_req_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        win_q     <= win_d;
                        ram_req_q <= 1'b1;
                        state_q   <= S_ISSUE;
                        case (win_d)
                            M_CPU: begin
                                ram_addr_q  <= cpu_addr_i;
                                ram_we_q    <= cpu_we_i;
                                ram_wdata_q <= cpu_wdata_i;
                                ram_wstrb_q <= cpu_wstrb_i;
`ifdef RAM_ARB_FAIR_EN
                                ptr_q       <= 1'b1;
`endif
                            end
                            M_DMA: begin
                                ram_addr_q  <= dma_addr_i;
                                ram_we_q    <= dma_we_i;
                                ram_wdata_q <= dma_wdata_i;
                                ram_wstrb_q <= dma_wstrb_i;
`ifdef RAM_ARB_FAIR_EN
                                ptr_q       <= 1'b0;
`endif
                            end
                            default: begin
                                // video is read-only; wdata is left as is
                                ram_addr_q  <= vid_addr_i;
                                ram_we_q    <= 1'b0;
                                ram_wstrb_q <= 2'b00;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_ack_i) begin
                        state_q <= S_DONE;
                        case (win_q)
                            M_CPU: begin
                                cpu_ack_q   <= 1'b1;
                                cpu_rdata_q <= ram_rdata_i;
                            end
                            M_DMA: begin
                                dma_ack_q   <= 1'b1;
                                dma_rdata_q <= ram_rdata_i;
                            end
                            default: begin
                                vid_ack_q   <= 1'b1;
                                vid_rdata_q <= ram_rdata_i;
                            end
                        endcase
                    end else if (cnt_q == TO_VAL) begin
                        // watchdog expired: complete with err, rdata untouched
                        state_q <= S_DONE;
                        case (win_q)
                            M_CPU: begin
                                cpu_ack_q <= 1'b1;
                                cpu_err_q <= 1'b1;
                            end
                            M_DMA: begin
                                dma_ack_q <= 1'b1;
                                dma_err_q <= 1'b1;
                            end
                            default: begin
                                vid_ack_q <= 1'b1;
                                vid_err_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    cnt_q   <= 4'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vid_ack_o   = vid_ack_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_ack_o   = dma_ack_q;
    assign vid_err_o   = vid_err_q;
    assign cpu_err_o   = cpu_err_q;
    assign dma_err_o   = dma_err_q;
    assign vid_rdata_o = vid_rdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign ram_req_o   = ram_req_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_wstrb_o = ram_wstrb_q;
    assign ram_we_o    = ram_we_q;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a small behavioural RAM. Inputs are driven
// and outputs sampled on the falling clock edge.

module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vid_req;
    logic [17:0] vid_addr;
    logic        vid_ack, vid_err;
    logic [15:0] vid_rdata;
    logic        cpu_req, cpu_we;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_wstrb;
    logic        cpu_ack, cpu_err;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [17:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [1:0]  dma_wstrb;
    logic        dma_ack, dma_err;
    logic [15:0] dma_rdata;
    logic        ram_req, ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  ram_wstrb;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = 16'h0000;

    logic        suppress;
    logic        stray;
    logic [15:0] mem [0:63];
    bit          mem_init = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    ram_arb #(.TIMEOUT(15)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .vid_req_i(vid_req), .vid_addr_i(vid_addr),
        .vid_ack_o(vid_ack), .vid_rdata_o(vid_rdata), .vid_err_o(vid_err),
        .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_we_i(cpu_we),
        .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
        .dma_req_i(dma_req), .dma_addr_i(dma_addr), .dma_we_i(dma_we),
        .dma_wdata_i(dma_wdata), .dma_wstrb_i(dma_wstrb),
        .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
        .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_wstrb_o(ram_wstrb), .ram_we_o(ram_we),
        .ram_ack_i(ram_ack), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: word i starts as 0xA000+i; acks one cycle after ram_req
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_init <= 1'b1;
        end
        ram_ack <= (ram_req && !suppress) || stray;
        if (ram_req) begin
            if (ram_we && ram_wstrb[0]) mem[ram_addr[6:1]][7:0]  <= ram_wdata[7:0];
            if (ram_we && ram_wstrb[1]) mem[ram_addr[6:1]][15:8] <= ram_wdata[15:8];
            ram_rdata <= mem[ram_addr[6:1]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            0:       return vid_ack;
            1:       return cpu_ack;
            default: return dma_ack;
        endcase
    endfunction

    // One access from master 'who' (0 vid, 1 cpu, 2 dma). Request is raised in
    // an IDLE cycle; lat is the cycle of the ack (-1 if it never came).
    // Returns at the ack sample point with the request already dropped.
    task automatic access(input int who, input logic we, input logic [17:0] addr,
                          input logic [15:0] wdata, input logic [1:0] wstrb,
                          output int lat);
        @(negedge clk);
        case (who)
            0: begin vid_addr = addr; vid_req = 1'b1; end
            1: begin cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;
                     cpu_wstrb = wstrb; cpu_req = 1'b1; end
            default: begin dma_addr = addr; dma_we = we; dma_wdata = wdata;
                     dma_wstrb = wstrb; dma_req = 1'b1; end
        endcase
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack_of(who)) begin
                lat = i;
                break;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        int lat;
        int t_vid, t_cpu, t_dma, t_last, n;
        logic [15:0] rd_vid, rd_cpu, rd_dma;
        logic [7:0]  seq;
        logic        seen;

        rstn = 1'b0; suppress = 1'b0; stray = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; cpu_wstrb = '0;
        dma_req = 1'b0; dma_addr = '0; dma_we = 1'b0; dma_wdata = '0; dma_wstrb = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pulses", {vid_ack, cpu_ack, dma_ack, vid_err, cpu_err, dma_err, ram_req}, 0);
        check("rst_ram", {ram_addr, ram_we, ram_wstrb, ram_wdata}, 0);
        check("rst_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // CPU write 0xBEEF to 0x00010, cycle by cycle
        cpu_addr = 18'h00010; cpu_we = 1'b1; cpu_wdata = 16'hBEEF; cpu_wstrb = 2'b11;
        cpu_req = 1'b1;
        @(negedge clk);
        check("wr_c1_req", ram_req, 1);
        check("wr_c1_fields", {ram_addr, ram_we, ram_wstrb, ram_wdata}, {18'h00010, 1'b1, 2'b11, 16'hBEEF});
        @(negedge clk);
        check("wr_c2_req_ack", {ram_req, cpu_ack}, 2'b00);
        @(negedge clk);
        check("wr_c3_ack_err", {cpu_ack, cpu_err}, 2'b10);
        cpu_req = 1'b0;
        @(negedge clk);
        check("wr_c4_ack", cpu_ack, 0);

        // read it back
        access(1, 1'b0, 18'h00010, 16'h0000, 2'b00, lat);
        check("rd_lat", lat, 3);
        check("rd_data", cpu_rdata, 16'hBEEF);
        check("rd_err", cpu_err, 0);

        // fresh reset so the tie pointer favours CPU again
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // all three request together: vid, cpu, dma, acks 4 cycles apart
        vid_addr = 18'h0000A; vid_req = 1'b1;
        cpu_addr = 18'h0000C; cpu_we = 1'b0; cpu_req = 1'b1;
        dma_addr = 18'h0000E; dma_we = 1'b0; dma_req = 1'b1;
        t_vid = -1; t_cpu = -1; t_dma = -1;
        rd_vid = '0; rd_cpu = '0; rd_dma = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (vid_ack) begin t_vid = i; rd_vid = vid_rdata; vid_req = 1'b0; end
            if (cpu_ack) begin t_cpu = i; rd_cpu = cpu_rdata; cpu_req = 1'b0; end
            if (dma_ack) begin t_dma = i; rd_dma = dma_rdata; dma_req = 1'b0; end
            if (t_dma != -1) break;
        end
        check("tri_t_vid", t_vid, 3);
        check("tri_t_cpu", t_cpu, 7);
        check("tri_t_dma", t_dma, 11);
        check("tri_rdata", {rd_vid, rd_cpu, rd_dma}, {16'hA005, 16'hA006, 16'hA007});

        // CPU and DMA both request continuously for 8 accesses
        @(negedge clk);
        cpu_addr = 18'h0000C; cpu_we = 1'b0; cpu_req = 1'b1;
        dma_addr = 18'h0000E; dma_we = 1'b0; dma_req = 1'b1;
        seq = '0; n = 0; t_last = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                seq[n[2:0]] = dma_ack;
                n++;
                if (n == 8) begin
                    t_last = i;
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                    break;
                end
            end
        end
`ifdef RAM_ARB_FAIR_EN
        check("rr_sequence", seq, 8'hAA);
`else
        check("fixed_sequence", seq, 8'h00);
`endif
        check("stream_t_last", t_last, 31);

        // byte-strobe write over 0xFFFF
        access(1, 1'b1, 18'h00020, 16'hFFFF, 2'b11, lat);
        check("bs_fill_err", {lat[7:0], cpu_err}, {8'd3, 1'b0});
        access(1, 1'b1, 18'h00020, 16'h1234, 2'b01, lat);
        access(1, 1'b0, 18'h00020, 16'h0000, 2'b00, lat);
        check("bs_readback", cpu_rdata, 16'hFF34);

        // DMA upper-byte write over 0xA011, read back by DMA
        access(2, 1'b1, 18'h00022, 16'h5A5A, 2'b10, lat);
        check("dma_wr_lat", lat, 3);
        access(2, 1'b0, 18'h00022, 16'h0000, 2'b00, lat);
        check("dma_readback", {dma_rdata, dma_err}, {16'h5A11, 1'b0});

        // unanswered access: ack with err 17 cycles after ISSUE, rdata kept
        suppress = 1'b1;
        access(1, 1'b0, 18'h0000C, 16'h0000, 2'b00, lat);
        check("to_lat", lat, 18);
        check("to_err", cpu_err, 1);
        check("to_rdata_kept", cpu_rdata, 16'hFF34);
        suppress = 1'b0;
        access(1, 1'b0, 18'h0000C, 16'h0000, 2'b00, lat);
        check("after_to", {lat[7:0], cpu_err, cpu_rdata}, {8'd3, 1'b0, 16'hA006});

        // reset during WAIT
        suppress = 1'b1;
        @(negedge clk);
        cpu_addr = 18'h00020; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        check("rw_issue", ram_req, 1);
        @(negedge clk);
        rstn = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rw_pulses", {vid_ack, cpu_ack, dma_ack, vid_err, cpu_err, dma_err, ram_req}, 0);
        check("rw_ram", {ram_addr, ram_we, ram_wstrb, ram_wdata}, 0);
        check("rw_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
        rstn = 1'b1;
        suppress = 1'b0;
        stray = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | vid_ack | cpu_ack | dma_ack | ram_req;
        end
        stray = 1'b0;
        check("rw_no_stale", seen, 0);
        @(negedge clk);
        access(1, 1'b0, 18'h0000C, 16'h0000, 2'b00, lat);
        check("rw_recover", {lat[7:0], cpu_err, cpu_rdata}, {8'd3, 1'b0, 16'hA006});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
